// File: rtl/dunc_pkg.sv
// dunc_pkg: definitions shared by the dunc accumulator core and its ALU.
//   OP_*    : opcode values, as found in the upper OPC_W bits of an instruction
//   state_e : sequencer states; the encoding is visible on the T_STATE debug port
package dunc_pkg;

  localparam int OP_LDA = 0;
  localparam int OP_STA = 1;
  localparam int OP_ADD = 2;
  localparam int OP_AND = 3;
  localparam int OP_JMP = 4;
  localparam int OP_JZ  = 5;
  localparam int OP_NOT = 6;
  localparam int OP_HLT = 7;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_E1   = 3'd3,
    ST_E2   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

endpackage

// File: rtl/dunc_alu.sv
// dunc_alu: combinational accumulator ALU.
//   i_opc    : opcode selecting the operation
//   i_ac     : current accumulator
//   i_md     : memory data operand
//   o_result : new accumulator value. Opcodes without an ALU function return i_ac.
//   o_zero   : high when i_ac is zero; JZ uses it
module dunc_alu
  import dunc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input  logic [OPC_W-1:0]  i_opc,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_md,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  localparam logic [OPC_W-1:0] C_LDA = OPC_W'(OP_LDA);
  localparam logic [OPC_W-1:0] C_ADD = OPC_W'(OP_ADD);
  localparam logic [OPC_W-1:0] C_AND = OPC_W'(OP_AND);
  localparam logic [OPC_W-1:0] C_NOT = OPC_W'(OP_NOT);

  always_comb begin
    o_result = i_ac;
    case (i_opc)
      C_LDA:   o_result = i_md;
      C_ADD:   o_result = i_ac + i_md;   // carry out is discarded
      C_AND:   o_result = i_ac & i_md;
      C_NOT:   o_result = ~i_ac;
      default: o_result = i_ac;
    endcase
  end

  assign o_zero = (i_ac == '0);

endmodule

// File: rtl/dunc.sv
// dunc_core: parametrised accumulator CPU. It has a ready-based memory handshake.
//   CLK, RESET (async, active-low)
//   MEM_ADDR/MEM_RD/MEM_WR/MEM_WDATA/MEM_RDATA/MEM_READY : memory port.
//     A strobe stays high until MEM_READY completes it.
//   FETCH/EXECUTE/T_STATE/HALTED : sequencer status
//   AC_OUT/PC_OUT/IR_OUT : register taps for debug
module dunc_core
  import dunc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int ADDR_W   = DATA_W - OPC_W,
  parameter int RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_READY,
  output logic              FETCH,
  output logic              EXECUTE,
  output logic [2:0]        T_STATE,
  output logic              HALTED,
  output logic [DATA_W-1:0] AC_OUT,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [OPC_W-1:0]  IR_OUT
);

  if (OPC_W < 3 || ADDR_W != DATA_W - OPC_W) begin : g_bad_params
    $error("dunc_core: needs OPC_W >= 3 and ADDR_W == DATA_W - OPC_W");
  end

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [OPC_W-1:0]  C_STA  = OPC_W'(OP_STA);
  localparam logic [OPC_W-1:0]  C_ADD  = OPC_W'(OP_ADD);
  localparam logic [OPC_W-1:0]  C_AND  = OPC_W'(OP_AND);
  localparam logic [OPC_W-1:0]  C_LDA  = OPC_W'(OP_LDA);
  localparam logic [OPC_W-1:0]  C_JMP  = OPC_W'(OP_JMP);
  localparam logic [OPC_W-1:0]  C_JZ   = OPC_W'(OP_JZ);
  localparam logic [OPC_W-1:0]  C_NOT  = OPC_W'(OP_NOT);
  localparam logic [OPC_W-1:0]  C_HLT  = OPC_W'(OP_HLT);

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ma;
  logic [DATA_W-1:0] r_md;
  logic [DATA_W-1:0] r_ac;
  logic [OPC_W-1:0]  r_ir;

  logic [OPC_W-1:0]  w_md_opc;
  logic [ADDR_W-1:0] w_md_addr;
  logic [OPC_W-1:0]  w_alu_opc;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_ac_zero;

  assign w_md_opc  = r_md[DATA_W-1 -: OPC_W];
  assign w_md_addr = r_md[ADDR_W-1:0];

  // In T2, IR is loaded on the same edge, so the ALU must decode the fetched word directly.
  assign w_alu_opc = (r_state == ST_T2) ? w_md_opc : r_ir;

  dunc_alu #(
    .DATA_W (DATA_W),
    .OPC_W  (OPC_W)
  ) u_alu (
    .i_opc    (w_alu_opc),
    .i_ac     (r_ac),
    .i_md     (r_md),
    .o_result (w_alu_result),
    .o_zero   (w_ac_zero)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_T0;
      r_pc    <= PC_RST;
      r_ac    <= '0;
      r_ir    <= '0;
      r_ma    <= '0;
      r_md    <= '0;
    end else begin
      case (r_state)
        ST_T0: begin
          r_ma    <= r_pc;
          r_state <= ST_T1;
        end
        ST_T1: begin
          if (MEM_READY) begin
            r_md    <= MEM_RDATA;
            r_pc    <= r_pc + 1'b1;   // wraps at 2**ADDR_W
            r_state <= ST_T2;
          end
        end
        ST_T2: begin
          r_ir    <= w_md_opc;
          r_ma    <= w_md_addr;
          r_state <= ST_T0;
          case (w_md_opc)
            C_JMP: r_pc <= w_md_addr;
            C_JZ:  if (w_ac_zero) r_pc <= w_md_addr;
            C_NOT: r_ac <= w_alu_result;
            C_HLT: r_state <= ST_HALT;
            C_LDA, C_STA, C_ADD, C_AND: r_state <= ST_E1;
            default: ;   // NOP
          endcase
        end
        ST_E1: begin
          if (MEM_READY) begin
            if (r_ir == C_STA) begin
              r_state <= ST_T0;
            end else begin
              r_md    <= MEM_RDATA;
              r_state <= ST_E2;
            end
          end
        end
        ST_E2: begin
          r_ac    <= w_alu_result;
          r_state <= ST_T0;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_T0;
      endcase
    end
  end

  // Strobes are decoded from registered state. The async reset clears them at once,
  // and an access cut off by reset is dropped.
  assign MEM_RD    = (r_state == ST_T1) || ((r_state == ST_E1) && (r_ir != C_STA));
  assign MEM_WR    = (r_state == ST_E1) && (r_ir == C_STA);
  assign MEM_ADDR  = r_ma;
  assign MEM_WDATA = r_ac;

  assign FETCH   = (r_state == ST_T0) || (r_state == ST_T1) || (r_state == ST_T2);
  assign EXECUTE = (r_state == ST_E1) || (r_state == ST_E2);
  assign T_STATE = r_state;
  assign HALTED  = (r_state == ST_HALT);
  assign AC_OUT  = r_ac;
  assign PC_OUT  = r_pc;
  assign IR_OUT  = r_ir;

endmodule

// File: tb/tb_dunc_core.sv
module tb_dunc_core;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int ADDR_W = 12;

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                stall;
  } txn_t;

  logic              CLK;
  logic              RESET;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_READY;
  logic              FETCH;
  logic              EXECUTE;
  logic [2:0]        T_STATE;
  logic              HALTED;
  logic [DATA_W-1:0] AC_OUT;
  logic [ADDR_W-1:0] PC_OUT;
  logic [OPC_W-1:0]  IR_OUT;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  txn_t              exp_q[$];
  int                stall_cycles;
  logic              idle_ready;
  int                checks;
  int                errors;

  dunc_core #(
    .DATA_W   (DATA_W),
    .OPC_W    (OPC_W),
    .ADDR_W   (ADDR_W),
    .RESET_PC (0)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_READY (MEM_READY),
    .FETCH     (FETCH),
    .EXECUTE   (EXECUTE),
    .T_STATE   (T_STATE),
    .HALTED    (HALTED),
    .AC_OUT    (AC_OUT),
    .PC_OUT    (PC_OUT),
    .IR_OUT    (IR_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers at the falling edge, after holding READY low for stall_cycles samples.
  int mcnt;
  always @(negedge CLK) begin
    if (!RESET) begin
      mcnt      = 0;
      MEM_READY = 1'b0;
      MEM_RDATA = 16'hDEAD;
    end else if (MEM_RD || MEM_WR) begin
      if (mcnt >= stall_cycles) begin
        MEM_READY = 1'b1;
        MEM_RDATA = mem[MEM_ADDR];
        if (MEM_WR) mem[MEM_ADDR] = MEM_WDATA;
        mcnt = 0;
      end else begin
        MEM_READY = 1'b0;
        MEM_RDATA = 16'hDEAD;
        mcnt++;
      end
    end else begin
      mcnt      = 0;
      MEM_READY = idle_ready;
      MEM_RDATA = 16'hDEAD;
    end
  end

  // Monitor: pops one expected access whenever a strobe completes.
  // It also checks that the address and strobe stay stable while stalled.
  int                stall_seen;
  logic              held;
  logic [ADDR_W-1:0] held_addr;
  logic              held_rd;
  always begin
    @(negedge CLK);
    #1;
    if (!RESET || !(MEM_RD || MEM_WR)) begin
      held       = 1'b0;
      stall_seen = 0;
    end else begin
      check("rd_wr_exclusive", {31'd0, MEM_RD & MEM_WR}, 32'd0);
      if (held) begin
        check("stall_addr_stable", 32'(MEM_ADDR), 32'(held_addr));
        check("stall_rd_stable", {31'd0, MEM_RD}, {31'd0, held_rd});
      end else begin
        held      = 1'b1;
        held_addr = MEM_ADDR;
        held_rd   = MEM_RD;
      end
      if (MEM_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got wr=%0b addr=0x%0h expected none", MEM_WR, MEM_ADDR);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          check("acc_kind", {31'd0, MEM_WR}, {31'd0, t.is_wr});
          check("acc_addr", 32'(MEM_ADDR), 32'(t.addr));
          if (t.is_wr) check("acc_wdata", 32'(MEM_WDATA), 32'(t.data));
          check("acc_stall", 32'(stall_seen), 32'(t.stall));
        end
        held       = 1'b0;
        stall_seen = 0;
      end else begin
        stall_seen++;
      end
    end
  end

  task automatic push(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.is_wr = w;
    t.addr  = a;
    t.data  = d;
    t.stall = stall_cycles;
    exp_q.push_back(t);
  endtask

  task automatic hold_reset();
    @(negedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h8000;   // NOP filler
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2 RESET = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!HALTED && cycles < limit) begin
      @(negedge CLK);
      cycles++;
    end
    if (!HALTED) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no halt expected halt within %0d cycles", name, limit);
    end
    @(negedge CLK);
    #3;
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_prog1();
    mem[0]  = 16'h0010;
    mem[1]  = 16'h2011;
    mem[2]  = 16'h1012;
    mem[3]  = 16'h7000;
    mem[16] = 16'h1234;
    mem[17] = 16'h0001;
    push(0, 12'h000, 0); push(0, 12'h010, 0);
    push(0, 12'h001, 0); push(0, 12'h011, 0);
    push(0, 12'h002, 0); push(1, 12'h012, 16'h1235);
    push(0, 12'h003, 0);
  endtask

  int cyc;
  int t2_seen;

  initial begin
    checks       = 0;
    errors       = 0;
    stall_cycles = 0;
    idle_ready   = 1'b0;
    RESET        = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    check("rst_state", 32'(T_STATE), 32'd0);
    check("rst_pc", 32'(PC_OUT), 32'd0);
    check("rst_ac", 32'(AC_OUT), 32'd0);
    check("rst_strobes", {30'd0, MEM_RD, MEM_WR}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd0);

    // 1: LDA/ADD/STA/HLT with READY high
    hold_reset();
    stall_cycles = 0;
    load_prog1();
    release_reset();
    run_to_halt("prog1", 200, cyc);
    check("prog1_cycles", 32'(cyc), 32'd17);
    check("prog1_mem18", 32'(mem[18]), 32'h1235);
    check("prog1_ac", 32'(AC_OUT), 32'h1235);
    check("prog1_halted", {31'd0, HALTED}, 32'd1);
    check("prog1_pc", 32'(PC_OUT), 32'd4);
    $display("prog1 done: ac=0x%0h pc=0x%0h cycles=%0d", AC_OUT, PC_OUT, cyc);

    // 2: same program, 3 READY-low cycles per access (7 accesses)
    hold_reset();
    stall_cycles = 3;
    load_prog1();
    release_reset();
    run_to_halt("prog2", 400, cyc);
    check("prog2_cycles", 32'(cyc), 32'd38);
    check("prog2_mem18", 32'(mem[18]), 32'h1235);
    check("prog2_ac", 32'(AC_OUT), 32'h1235);
    check("prog2_pc", 32'(PC_OUT), 32'd4);
    $display("prog2 done: ac=0x%0h pc=0x%0h cycles=%0d", AC_OUT, PC_OUT, cyc);

    // 3a: AC=0, JZ taken
    hold_reset();
    stall_cycles = 0;
    mem[0] = 16'h0010; mem[16] = 16'h0000; mem[1] = 16'h5020; mem[12'h20] = 16'h7000;
    push(0, 12'h000, 0); push(0, 12'h010, 0); push(0, 12'h001, 0); push(0, 12'h020, 0);
    release_reset();
    run_to_halt("jz_taken", 200, cyc);
    check("jz_taken_pc", 32'(PC_OUT), 32'h021);
    $display("jz_taken done: pc=0x%0h", PC_OUT);

    // 3b: AC=1, JZ not taken
    hold_reset();
    mem[0] = 16'h0010; mem[16] = 16'h0001; mem[1] = 16'h5020; mem[2] = 16'h7000;
    mem[12'h20] = 16'h7000;
    push(0, 12'h000, 0); push(0, 12'h010, 0); push(0, 12'h001, 0); push(0, 12'h002, 0);
    release_reset();
    run_to_halt("jz_not", 200, cyc);
    check("jz_not_pc", 32'(PC_OUT), 32'h003);
    check("jz_not_ac", 32'(AC_OUT), 32'h0001);
    $display("jz_not done: pc=0x%0h", PC_OUT);

    // 4: fetch from 0xFFF wraps PC to 0, then JMP 0x005
    hold_reset();
    mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h4005; mem[5] = 16'h7000;
    push(0, 12'h000, 0); push(0, 12'hFFF, 0); push(0, 12'h005, 0);
    release_reset();
    t2_seen = 0;
    for (int i = 0; i < 50 && t2_seen < 2; i++) begin
      @(negedge CLK);
      if (T_STATE == 3'd2) t2_seen++;
    end
    check("wrap_t2_reached", 32'(t2_seen), 32'd2);
    check("wrap_pc_zero", 32'(PC_OUT), 32'h000);
    run_to_halt("wrap", 200, cyc);
    check("wrap_pc_final", 32'(PC_OUT), 32'h006);
    $display("wrap done: pc=0x%0h", PC_OUT);

    // 5: async reset during a stalled LDA read in E1
    hold_reset();
    stall_cycles = 2;
    mem[0] = 16'h0010; mem[16] = 16'h5555; mem[1] = 16'h0011; mem[17] = 16'h7777;
    push(0, 12'h000, 0); push(0, 12'h010, 0); push(0, 12'h001, 0);
    release_reset();
    cyc = 0;
    while (!(T_STATE == 3'd3 && MEM_ADDR == 12'h011) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check("abort_reached_e1", {31'd0, (T_STATE == 3'd3 && MEM_ADDR == 12'h011)}, 32'd1);
    stall_cycles = 50;   // the model keeps READY low for the rest of this access
    @(negedge CLK);
    #2;
    check("abort_rd_before", {31'd0, MEM_RD}, 32'd1);
    check("abort_ac_before", 32'(AC_OUT), 32'h5555);
    RESET = 1'b0;
    #1;
    check("abort_rd_fell", {31'd0, MEM_RD}, 32'd0);
    check("abort_state", 32'(T_STATE), 32'd0);
    check("abort_ac_clear", 32'(AC_OUT), 32'd0);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    stall_cycles = 0;
    mem[0] = 16'h7000;
    push(0, 12'h000, 0);
    release_reset();
    run_to_halt("after_abort", 100, cyc);
    check("after_abort_pc", 32'(PC_OUT), 32'd1);
    check("after_abort_ac", 32'(AC_OUT), 32'd0);
    $display("abort done: pc=0x%0h ac=0x%0h", PC_OUT, AC_OUT);

    // 6: NOT, opcode 0xF as NOP, then READY toggling while halted
    hold_reset();
    mem[0] = 16'h0010; mem[16] = 16'h00FF; mem[1] = 16'h6000; mem[2] = 16'hF000; mem[3] = 16'h7000;
    push(0, 12'h000, 0); push(0, 12'h010, 0); push(0, 12'h001, 0);
    push(0, 12'h002, 0); push(0, 12'h003, 0);
    release_reset();
    run_to_halt("not_nop", 200, cyc);
    check("not_ac", 32'(AC_OUT), 32'hFF00);
    check("not_pc", 32'(PC_OUT), 32'd4);
    for (int i = 0; i < 10; i++) begin
      idle_ready = ~idle_ready;
      @(negedge CLK);
      #2;
      check("halt_no_strobe", {30'd0, MEM_RD, MEM_WR}, 32'd0);
      check("halt_pc_frozen", 32'(PC_OUT), 32'd4);
    end
    idle_ready = 1'b0;
    check("halt_still", {31'd0, HALTED}, 32'd1);
    $display("not_nop done: ac=0x%0h pc=0x%0h", AC_OUT, PC_OUT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
